fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx_if.sv | 41 ++++
 rtl/fifo_uart_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx_if
//  Description : Bundle of FIFO-side and line-side signals of the FIFO-fed
//                UART transmitter. The slave modport is the transmitter view;
//                the master modport is the view of whatever drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if;
    logic        tx_en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;

    modport master (
        output tx_en,
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        input  tx,
        input  busy,
        input  frame_done,
        input  frame_cnt
    );

    modport slave (
        input  tx_en,
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        output tx,
        output busy,
        output frame_done,
        output frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_uart_tx
//  Description : UART transmitter that pops bytes from an upstream FIFO with
//                registered read data and sends them LSB first, 8 data bits,
//                one stop bit. Back-to-back frames carry no idle gap.
//                Optional even parity bit when FIFO_UART_TX_PARITY_EN is
//                defined (frame becomes 11 bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic           clock,
    input  logic           rst,
    fifo_uart_tx_if.slave  bus
);

    localparam logic [15:0] c_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_IDX_LAST = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_timer;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic [15:0] r_frame_cnt;
    logic        w_bit_end;
    logic        w_line_state;
    logic        w_want_pop;
    logic        w_tx;

    assign w_bit_end  = (r_timer == c_BIT_LAST);
    assign w_want_pop = bus.tx_en && !bus.fifo_empty;

    // States in which the bit timer runs (a serial bit is on the line)
    always_comb begin
        w_line_state = 1'b0;
        case (r_state)
            S_START, S_DATA, S_STOP: w_line_state = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY:                w_line_state = 1'b1;
`endif
            default:                 w_line_state = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state decode; the FIFO flag is only looked at in IDLE and on the
    // final stop cycle so a new frame chains straight onto the previous one
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_want_pop) w_next_state = S_POP;
            S_POP:   w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_START;
            S_START: if (w_bit_end) w_next_state = S_DATA;
`ifdef FIFO_UART_TX_PARITY_EN
            S_DATA:   if (w_bit_end && (r_idx == c_IDX_LAST)) w_next_state = S_PARITY;
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
`else
            S_DATA:   if (w_bit_end && (r_idx == c_IDX_LAST)) w_next_state = S_STOP;
`endif
            S_STOP:  if (w_bit_end) w_next_state = w_want_pop ? S_POP : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Bit timer: restarts at every bit boundary, parked at 0 off the line
    always_ff @(posedge clock or posedge rst) begin
        if (rst)                          r_timer <= '0;
        else if (w_line_state && !w_bit_end) r_timer <= r_timer + 16'd1;
        else                              r_timer <= '0;
    end

    // Data bit index: advances on each data-bit boundary, cleared outside DATA
    always_ff @(posedge clock or posedge rst) begin
        if (rst)                               r_idx <= '0;
        else if (r_state != S_DATA)            r_idx <= '0;
        else if (w_bit_end)                    r_idx <= r_idx + 3'd1;
    end

    // Shift register: loaded in LOAD (read data valid the cycle after the
    // pop), shifted right at each data-bit boundary
    always_ff @(posedge clock or posedge rst) begin
        if (rst)                                   r_shift <= '0;
        else if (r_state == S_LOAD)                r_shift <= bus.fifo_data;
        else if ((r_state == S_DATA) && w_bit_end) r_shift <= {1'b0, r_shift[7:1]};
    end

`ifdef FIFO_UART_TX_PARITY_EN
    logic r_parity;

    // Even parity captured with the byte, before shifting destroys it
    always_ff @(posedge clock or posedge rst) begin
        if (rst)                    r_parity <= 1'b0;
        else if (r_state == S_LOAD) r_parity <= ^bus.fifo_data;
    end
`endif

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clock or posedge rst) begin
        if (rst)                                   r_frame_cnt <= '0;
        else if ((r_state == S_STOP) && w_bit_end) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    // Line level decoded from state so reset forces idle-high immediately
    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            S_START:  w_tx = 1'b0;
            S_DATA:   w_tx = r_shift[0];
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: w_tx = r_parity;
`endif
            default:  w_tx = 1'b1;
        endcase
    end

    assign bus.tx         = w_tx;
    assign bus.fifo_rd    = (r_state == S_POP);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = (r_state == S_STOP) && w_bit_end;
    assign bus.frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_uart_tx
//  Description : Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4.
//                Expected frames are built from the byte value (start, data
//                LSB first, optional parity, stop); a byte queue and a frame
//                count form the reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int LIMIT = 200;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clock;
    logic rst;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Upstream FIFO with registered read data; never reset, so a popped byte
    // is gone for good
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] fdata  = 8'h00;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_data  = fdata;

    always @(posedge clock) begin
        if (bus.fifo_rd === 1'b1) begin
            fdata  <= mem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Reference model state
    logic [7:0]  exp_q[$];
    logic [15:0] exp_cnt;
    int          total = 0;
    int          bad   = 0;

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 256] = b;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(b);
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (NB == 11) f[9] = ^b;
        return f;
    endfunction

    // Waits (bounded) for the pop strobe; returns at the negedge of the POP cycle
    task automatic wait_pop(output int waited, output bit ok);
        waited = 0;
        @(negedge clock);
        while (bus.fifo_rd !== 1'b1 && waited < LIMIT) begin
            @(negedge clock);
            waited++;
        end
        ok = (bus.fifo_rd === 1'b1);
    endtask

    // Records one frame from the LOAD cycle through the last stop cycle
    task automatic capture_frame(input int drop_at, output logic [10:0] bits,
                                 output bit held_ok, output int done_at,
                                 output int done_cnt, output bit load_ok);
        @(negedge clock);
        load_ok  = (bus.tx === 1'b1) && (bus.fifo_rd === 1'b0) && (bus.busy === 1'b1);
        bits     = '1;
        held_ok  = 1'b1;
        done_at  = -1;
        done_cnt = 0;
        for (int i = 0; i < NB * CPB; i++) begin
            @(negedge clock);
            if (i == drop_at) bus.tx_en = 1'b0;
            if (i % CPB == 0) bits[i / CPB] = bus.tx;
            else if (bus.tx !== bits[i / CPB]) held_ok = 1'b0;
            if (bus.busy !== 1'b1 || bus.fifo_rd !== 1'b0) held_ok = 1'b0;
            if (bus.frame_done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
        end
    endtask

    // Pops one expected byte and checks the whole frame against the model
    task automatic send_and_check(input string tag, input int drop_at);
        int          waited;
        bit          ok, held_ok, load_ok;
        logic [10:0] bits, exp;
        int          done_at, done_cnt;
        logic [7:0]  b;
        wait_pop(waited, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s pop: no fifo_rd within %0d cycles", tag, LIMIT);
            return;
        end
        b   = exp_q.pop_front();
        exp = exp_frame(b);
        capture_frame(drop_at, bits, held_ok, done_at, done_cnt, load_ok);
        exp_cnt = exp_cnt + 16'd1;
        total++;
        if (bits !== exp) begin
            bad++;
            $display("FAIL %s bits: got %b want %b (byte %h)", tag, bits, exp, b);
        end
        total++;
        if (!held_ok || !load_ok) begin
            bad++;
            $display("FAIL %s timing: held_ok=%0d load_ok=%0d want 1 1", tag, held_ok, load_ok);
        end
        total++;
        if (done_cnt != 1 || done_at != NB * CPB - 1) begin
            bad++;
            $display("FAIL %s frame_done: count=%0d at=%0d want 1 at %0d",
                     tag, done_cnt, done_at, NB * CPB - 1);
        end
    endtask

    task automatic test_reset();
        bus.tx_en = 1'b1;
        rst       = 1'b0;
        #2 rst    = 1'b1;
        #1;
        exp_cnt = 16'h0000;
        total++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0 ||
            bus.fifo_rd !== 1'b0 || bus.frame_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state: tx=%b busy=%b done=%b rd=%b cnt=%h want 1 0 0 0 0000",
                     bus.tx, bus.busy, bus.frame_done, bus.fifo_rd, bus.frame_cnt);
        end
        push(8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            total++;
            if (bus.fifo_rd !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold: rd=%b busy=%b want 0 0", bus.fifo_rd, bus.busy);
            end
        end
    endtask

    task automatic test_single();
        rst = 1'b0;
        send_and_check("single_A5", -1);
        @(negedge clock);
        total++;
        if (bus.frame_cnt !== exp_cnt || bus.busy !== 1'b0 || bus.fifo_rd !== 1'b0) begin
            bad++;
            $display("FAIL single_after: cnt=%h busy=%b rd=%b want %h 0 0",
                     bus.frame_cnt, bus.busy, bus.fifo_rd, exp_cnt);
        end
    endtask

    task automatic test_back_to_back(input int n, input bit rnd);
        int  waited;
        bit  ok;
        for (int k = 0; k < n; k++) push(rnd ? 8'($urandom) : 8'(k + 1));
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                // The next POP must be the cycle right after the last stop cycle
                @(negedge clock);
                total++;
                if (bus.fifo_rd !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_gap: frame %0d rd=%b want 1", k, bus.fifo_rd);
                end
                ok = (bus.fifo_rd === 1'b1);
                if (ok) begin : chained
                    logic [10:0] bits, exp;
                    bit          held_ok, load_ok;
                    int          done_at, done_cnt;
                    logic [7:0]  b;
                    b   = exp_q.pop_front();
                    exp = exp_frame(b);
                    capture_frame(-1, bits, held_ok, done_at, done_cnt, load_ok);
                    exp_cnt = exp_cnt + 16'd1;
                    total++;
                    if (bits !== exp || !held_ok || !load_ok || done_cnt != 1) begin
                        bad++;
                        $display("FAIL b2b_frame: frame %0d bits=%b want %b held=%0d load=%0d done=%0d",
                                 k, bits, exp, held_ok, load_ok, done_cnt);
                    end
                end
                else begin
                    wait_pop(waited, ok);
                    return;
                end
            end
            else begin
                send_and_check("b2b_first", -1);
            end
        end
        @(negedge clock);
        total++;
        if (bus.frame_cnt !== exp_cnt || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_cnt: cnt=%h busy=%b want %h 0", bus.frame_cnt, bus.busy, exp_cnt);
        end
    endtask

    task automatic test_tx_en_drop();
        bit saw_rd;
        push(8'h55);
        push(8'($urandom));
        // Drop tx_en in the middle of data bit 1
        send_and_check("drop_55", 2 * CPB + 1);
        saw_rd = 1'b0;
        @(negedge clock);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_busy: busy=%b want 0", bus.busy);
        end
        for (int i = 0; i < 3 * CPB; i++) begin
            if (bus.fifo_rd === 1'b1) saw_rd = 1'b1;
            @(negedge clock);
        end
        total++;
        if (saw_rd || bus.frame_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL drop_no_pop: saw_rd=%0d cnt=%h want 0 %h", saw_rd, bus.frame_cnt, exp_cnt);
        end
        bus.tx_en = 1'b1;
        send_and_check("drop_resume", -1);
    endtask

    task automatic test_reset_mid();
        int         waited;
        bit         ok;
        logic [7:0] b;
        push(8'hF0);
        push(8'($urandom));
        wait_pop(waited, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid_pop: no fifo_rd within %0d cycles", LIMIT);
            return;
        end
        b = exp_q.pop_front();
        @(negedge clock);                           // LOAD
        for (int i = 0; i <= 4 * CPB + 1; i++) @(negedge clock);  // mid data bit 3
        total++;
        if (bus.tx !== b[3]) begin
            bad++;
            $display("FAIL rstmid_bit3: tx=%b want %b", bus.tx, b[3]);
        end
        rst = 1'b1;
        #1;
        exp_cnt = 16'h0000;
        total++;
        if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.frame_cnt !== exp_cnt || bus.fifo_rd !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_async: tx=%b busy=%b cnt=%h rd=%b want 1 0 0000 0",
                     bus.tx, bus.busy, bus.frame_cnt, bus.fifo_rd);
        end
        @(negedge clock);
        total++;
        if (bus.fifo_rd !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_hold: rd=%b want 0", bus.fifo_rd);
        end
        rst = 1'b0;
        send_and_check("rstmid_next", -1);
    endtask

    task automatic test_wrap();
        @(negedge clock);
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        exp_cnt = 16'hFFFF;
        total++;
        if (bus.frame_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL wrap_preload: cnt=%h want %h", bus.frame_cnt, exp_cnt);
        end
        push(8'($urandom));
        send_and_check("wrap", -1);
        @(negedge clock);
        total++;
        if (bus.frame_cnt !== 16'h0000 || bus.frame_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL wrap_cnt: cnt=%h want 0000", bus.frame_cnt);
        end
    endtask

    initial begin
        bus.tx_en = 1'b0;
        test_reset();
        test_single();
        test_back_to_back(3, 1'b0);
        test_back_to_back(6, 1'b1);
        test_tx_en_drop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
